div: RTL

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_negate.sv | 23 ++
 rtl/div.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    // Default operand/result width of the divider.
    localparam int DIV_WIDTH = 32;

    // Control states of the divider sequencer.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } div_state_t;

    // True when a value is negative under two's-complement interpretation.
    function automatic logic is_neg(input logic msb, input logic issigned);
        is_neg = msb & issigned;
    endfunction

endpackage

// File: rtl/div_negate.sv
// Conditional two's-complement negation: dout = neg ? -din : din.
// Used for operand magnitudes and for applying the result signs.
module div_negate
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    output logic [WIDTH-1:0] dout
);

    // Invert-and-increment when negation is requested, pass through otherwise.
    always_comb begin
        dout = din;
        if (neg) begin
            dout = ~din + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            dout = din;
        end
    end

endmodule

// File: rtl/div.sv
// Sequential restoring divider, one shift-subtract step per clock.
// Signed operation divides magnitudes and fixes the signs afterwards, so the
// quotient truncates toward zero and the remainder follows the dividend sign.
module div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             issigned,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divzero
);

    localparam logic [WIDTH-1:0] LAST_CNT = (WIDTH)'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    div_state_t       state_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] a_orig_r;     // original dividend, returned as remainder on b == 0
    logic [WIDTH-1:0] bmag_r;       // divisor magnitude
    logic [WIDTH-1:0] quo_r;        // dividend bits shift out, quotient bits shift in
    logic [WIDTH:0]   rem_r;        // partial remainder
    logic             sign_q_r;
    logic             sign_r_r;
    logic             bzero_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             divzero_r;

    logic             a_neg_s;
    logic             b_neg_s;
    logic             bzero_s;
    logic [WIDTH-1:0] amag_s;
    logic [WIDTH-1:0] bmag_s;
    logic [WIDTH-1:0] qres_s;
    logic [WIDTH-1:0] rres_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] diff_s;
    logic             fits_s;
    logic [WIDTH:0]   rem_next_s;
    logic [WIDTH-1:0] quo_next_s;

    assign a_neg_s = is_neg(a[WIDTH-1], issigned);
    assign b_neg_s = is_neg(b[WIDTH-1], issigned);
    assign bzero_s = (b == {WIDTH{1'b0}});

    div_negate #(.WIDTH(WIDTH)) u_amag (.din(a),                 .neg(a_neg_s),  .dout(amag_s));
    div_negate #(.WIDTH(WIDTH)) u_bmag (.din(b),                 .neg(b_neg_s),  .dout(bmag_s));
    div_negate #(.WIDTH(WIDTH)) u_qfix (.din(quo_r),             .neg(sign_q_r), .dout(qres_s));
    div_negate #(.WIDTH(WIDTH)) u_rfix (.din(rem_r[WIDTH-1:0]),  .neg(sign_r_r), .dout(rres_s));

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    always_comb begin
        shift_s    = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
        diff_s     = {rem_r[WIDTH], shift_s} - {2'b00, bmag_r};
        fits_s     = ~diff_s[WIDTH+1];
        rem_next_s = shift_s;
        if (fits_s) begin
            rem_next_s = diff_s[WIDTH:0];
        end else begin
            rem_next_s = shift_s;
        end
        quo_next_s = {quo_r[WIDTH-2:0], fits_s};
    end

    // Sequencer, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= {WIDTH{1'b0}};
            a_orig_r    <= {WIDTH{1'b0}};
            bmag_r      <= {WIDTH{1'b0}};
            quo_r       <= {WIDTH{1'b0}};
            rem_r       <= {(WIDTH+1){1'b0}};
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            bzero_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            divzero_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_orig_r <= a;
                        bmag_r   <= bmag_s;
                        quo_r    <= amag_s;
                        rem_r    <= {(WIDTH+1){1'b0}};
                        cnt_r    <= {WIDTH{1'b0}};
                        sign_q_r <= a_neg_s ^ b_neg_s;
                        sign_r_r <= a_neg_s;
                        bzero_r  <= bzero_s;
                        busy_r   <= 1'b1;
                        if (bzero_s) begin
                            state_r <= FIXUP;
                        end else begin
                            state_r <= RUN;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= FIXUP;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIXUP: begin
                    if (bzero_r) begin
                        quotient_r  <= {WIDTH{1'b1}};
                        remainder_r <= a_orig_r;
                        divzero_r   <= 1'b1;
                    end else begin
                        quotient_r  <= qres_s;
                        remainder_r <= rres_s;
                        divzero_r   <= 1'b0;
                    end
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= DONE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign divzero   = divzero_r;

endmodule
